scene_renderer: RTL

Pixel source for the dinosaur game display: answers the VGA controller's `row_addr`/`col_addr` requests with the 12-bit colour of that pixel on `d_out`, which feeds the controller's `d_in`. Game state (`game_status`, `dinosaur_height`, `ground_position`) is snapshotted once per frame, so a frame never tears. The block also reports dinosaur/obstacle pixel overlap back to the game logic.

---
 rtl/scene_renderer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/scene_renderer.sv
// scene_renderer
// Pixel source for the dinosaur game display. Answers VGA row/column requests
// with a 12-bit RGB 4:4:4 colour two cycles later. Game state is snapshotted
// into shadow registers at every frame start, so a frame never tears. It also
// reports dinosaur/obstacle pixel overlap back to the game logic.
//
// Optional feature macro: SCENE_COLLIDE_EN
//   defined   - collision accumulator and collide register are built
//   undefined - collide is tied to 0 and the accumulator is removed
//
// Ports:
//   CLK             in   pixel clock (shared with the VGA controller)
//   clrn            in   asynchronous active-low reset
//   row_addr[8:0]   in   requested row
//   col_addr[9:0]   in   requested column
//   game_status     in   1 = running, 0 = game over
//   dinosaur_height in   jump height in units
//   ground_position in   scroll position
//   d_out[11:0]     out  pixel colour for the requested address
//   frame_tick      out  one-cycle pulse aligned with d_out of pixel (0,0)
//   collide         out  high for the whole frame after a frame with overlap
module scene_renderer #(
  parameter int unsigned GROUND_ROW   = 400,
  parameter int unsigned DINO_COL     = 64,
  parameter int unsigned DINO_W       = 32,
  parameter int unsigned DINO_H       = 40,
  parameter int unsigned HEIGHT_SCALE = 4,
  parameter int unsigned OBST_W       = 16,
  parameter int unsigned OBST_H       = 32
) (
  input  logic        CLK,
  input  logic        clrn,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        game_status,
  input  logic [5:0]  dinosaur_height,
  input  logic [5:0]  ground_position,
  output logic [11:0] d_out,
  output logic        frame_tick,
  output logic        collide
);

  localparam logic [11:0] ColBand   = 12'hF00;
  localparam logic [11:0] ColDino   = 12'h353;
  localparam logic [11:0] ColObst   = 12'h383;
  localparam logic [11:0] ColGround = 12'h555;
  localparam logic [11:0] ColSky    = 12'hFFF;
  localparam logic [11:0] ColOff    = 12'h000;

  localparam logic [9:0] TopBase = 10'(GROUND_ROW - DINO_H);

  // Frame start detection
  logic w_addr_zero;
  logic w_frame_start;
  logic r_prev_zero;

  // Stage 1 and shadow state
  logic [8:0] r_s1_row;
  logic [9:0] r_s1_col;
  logic       r_s1_fs;
  logic       r_sh_status;
  logic [5:0] r_sh_height;
  logic [5:0] r_sh_ground;
  logic [5:0] r_frame_cnt;

  // Stage 2
  logic [11:0] r_d_out;
  logic        r_frame_tick;

  // Hit computation
  logic [9:0]  w_row10;
  logic [9:0]  w_lift;
  logic [9:0]  w_top;
  logic [9:0]  w_top_end;
  logic [9:0]  w_ox;
  logic [9:0]  w_ox_end;
  logic        w_visible;
  logic        w_hit_dino;
  logic        w_hit_obst;
  logic        w_hit_ground;
  logic        w_hit_band;
  logic [11:0] w_colour;

  // Only the first (0,0) after any other address starts a frame, so a
  // controller parked on (0,0) does not retrigger.
  assign w_addr_zero   = (row_addr == 9'd0) && (col_addr == 10'd0);
  assign w_frame_start = w_addr_zero && !r_prev_zero;

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      r_prev_zero <= 1'b0;
      r_s1_row    <= '0;
      r_s1_col    <= '0;
      r_s1_fs     <= 1'b0;
      r_sh_status <= 1'b0;
      r_sh_height <= '0;
      r_sh_ground <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_prev_zero <= w_addr_zero;
      r_s1_row    <= row_addr;
      r_s1_col    <= col_addr;
      r_s1_fs     <= w_frame_start;
      if (w_frame_start) begin
        r_sh_status <= game_status;
        r_sh_height <= dinosaur_height;
        r_sh_ground <= ground_position;
        r_frame_cnt <= r_frame_cnt + 6'd1;
      end
    end
  end

  assign w_row10 = {1'b0, r_s1_row};

  // Dinosaur top edge clamps at row 0 when the jump lifts it past the screen.
  assign w_lift    = 10'(r_sh_height * HEIGHT_SCALE);
  assign w_top     = (w_lift > TopBase) ? 10'd0 : (TopBase - w_lift);
  assign w_top_end = w_top + 10'(DINO_H);

  assign w_ox     = 10'd639 - (10'd10 * {4'b0, r_sh_ground});
  assign w_ox_end = w_ox + 10'(OBST_W);

  assign w_visible = (r_s1_col < 10'd640) && (r_s1_row < 9'd480);

  assign w_hit_dino = (r_s1_col >= 10'(DINO_COL)) && (r_s1_col < 10'(DINO_COL + DINO_W)) &&
                      (w_row10 >= w_top) && (w_row10 < w_top_end);

  assign w_hit_obst = (r_s1_col >= w_ox) && (r_s1_col < w_ox_end) &&
                      (w_row10 >= 10'(GROUND_ROW - OBST_H)) && (w_row10 < 10'(GROUND_ROW));

  assign w_hit_ground = (w_row10 == 10'(GROUND_ROW)) || (w_row10 == 10'(GROUND_ROW + 1));

  // Band blinks with a 64-frame period: hidden for counts 0..31, shown 32..63.
  assign w_hit_band = !r_sh_status && r_frame_cnt[5] &&
                      (w_row10 >= 10'd200) && (w_row10 <= 10'd231) &&
                      (r_s1_col >= 10'd256) && (r_s1_col <= 10'd383);

  always_comb begin
    w_colour = ColSky;
    if (!w_visible) begin
      w_colour = ColOff;
    end else if (w_hit_band) begin
      w_colour = ColBand;
    end else if (w_hit_dino) begin
      w_colour = ColDino;
    end else if (w_hit_obst) begin
      w_colour = ColObst;
    end else if (w_hit_ground) begin
      w_colour = ColGround;
    end
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      r_d_out      <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_d_out      <= w_colour;
      r_frame_tick <= r_s1_fs;
    end
  end

  assign d_out      = r_d_out;
  assign frame_tick = r_frame_tick;

`ifdef SCENE_COLLIDE_EN
  logic w_hit_both;
  logic r_acc;
  logic r_collide;

  assign w_hit_both = w_visible && w_hit_dino && w_hit_obst;

  // At frame start the finished frame's result moves to collide and the
  // accumulator restarts with pixel (0,0) of the new frame.
  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      r_acc     <= 1'b0;
      r_collide <= 1'b0;
    end else if (r_s1_fs) begin
      r_collide <= r_acc;
      r_acc     <= w_hit_both;
    end else begin
      r_acc     <= r_acc | w_hit_both;
    end
  end

  assign collide = r_collide;
`else
  assign collide = 1'b0;
`endif

endmodule
